// File: rtl/div_sequencer_if.sv
// div_sequencer_if: EXE <-> divide sequencer request/response bundle.
//   master : EXE side (drives REQ_*, FLUSH, RESP_READY)
//   slave  : sequencer side (drives REQ_READY, RESP_*, BUSY)
//   REQ_CMD encoding: 01 DIV, 10 DIVU, 11 REM, 00 REMU.
interface div_sequencer_if #(
  parameter int TAG_W = 5
);
  logic             REQ_VALID;
  logic             REQ_READY;
  logic [31:0]      REQ_OP1;
  logic [31:0]      REQ_OP2;
  logic [1:0]       REQ_CMD;
  logic [TAG_W-1:0] REQ_TAG;
  logic             FLUSH;
  logic             RESP_VALID;
  logic             RESP_READY;
  logic [31:0]      RESP_DATA;
  logic [TAG_W-1:0] RESP_TAG;
  logic             BUSY;

  modport master (
    output REQ_VALID, REQ_OP1, REQ_OP2, REQ_CMD, REQ_TAG, FLUSH, RESP_READY,
    input  REQ_READY, RESP_VALID, RESP_DATA, RESP_TAG, BUSY
  );

  modport slave (
    input  REQ_VALID, REQ_OP1, REQ_OP2, REQ_CMD, REQ_TAG, FLUSH, RESP_READY,
    output REQ_READY, RESP_VALID, RESP_DATA, RESP_TAG, BUSY
  );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: issue/completion controller between EXE and an iterative
// divider. One request outstanding at a time; operands/command are held in
// registers and driven to the divider from launch through DIV_DONE; the
// result is returned with its tag over a valid/ready channel.
//
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset
//   exe (slave)       : REQ_* request, RESP_* response, FLUSH, BUSY
//   DIV_START         : one-cycle launch pulse to the divider
//   DIV_OP1/OP2/CMD   : operands and command to the divider
//   DIV_DONE/RES/BUSY : divider completion pulse, result, busy
//   ERR_TIMEOUT       : sticky, divider missed the TIMEOUT deadline
//
// Optional: define DIV_MEMO_EN to add a one-entry result memo that lets a
// repeated {op1, op2, cmd} request complete without launching the divider.
module div_sequencer #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64   // 2..256
) (
  input  logic        clk,
  input  logic        reset_n,
  div_sequencer_if.slave exe,
  output logic        DIV_START,
  output logic [31:0] DIV_OP1,
  output logic [31:0] DIV_OP2,
  output logic [1:0]  DIV_CMD,
  input  logic        DIV_DONE,
  input  logic        DIV_BUSY,
  input  logic [31:0] DIV_RES,
  output logic        ERR_TIMEOUT
);

  typedef enum logic [2:0] {IDLE, START, WAIT, RESP, DRAIN} state_t;

  // The counter is cleared in the launch cycle, so in WAIT/DRAIN cnt_q+2
  // cycles have elapsed counting both the launch cycle and the current one.
  localparam logic [7:0] DEADLINE = 8'(TIMEOUT - 2);

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             rvld_q, rvld_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [31:0]      op1_q, op1_d, op2_q, op2_d, data_q, data_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             accept, launch, timeout_hit, memo_hit;
  logic [31:0]      memo_data;

  assign accept      = (state_q == IDLE) && ready_q && exe.REQ_VALID && !exe.FLUSH;
  // Launch must see DIV_BUSY in the same cycle, so it is decoded from the
  // state flop rather than registered.
  assign launch      = (state_q == START) && !DIV_BUSY;
  assign timeout_hit = (cnt_q == DEADLINE) && !DIV_DONE;

`ifdef DIV_MEMO_EN
  logic        memo_vld_q, memo_vld_d;
  logic [31:0] memo_op1_q, memo_op1_d, memo_op2_q, memo_op2_d;
  logic [31:0] memo_res_q, memo_res_d;
  logic [1:0]  memo_cmd_q, memo_cmd_d;

  assign memo_hit  = memo_vld_q && (exe.REQ_OP1 == memo_op1_q) &&
                     (exe.REQ_OP2 == memo_op2_q) && (exe.REQ_CMD == memo_cmd_q);
  assign memo_data = memo_res_q;

  // Only a completion that is actually delivered refreshes the memo.
  always_comb begin
    memo_vld_d = memo_vld_q;
    memo_op1_d = memo_op1_q;
    memo_op2_d = memo_op2_q;
    memo_cmd_d = memo_cmd_q;
    memo_res_d = memo_res_q;
    if ((state_q == WAIT) && DIV_DONE && !exe.FLUSH) begin
      memo_vld_d = 1'b1;
      memo_op1_d = op1_q;
      memo_op2_d = op2_q;
      memo_cmd_d = cmd_q;
      memo_res_d = DIV_RES;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      memo_vld_q <= 1'b0;
      memo_op1_q <= '0;
      memo_op2_q <= '0;
      memo_cmd_q <= '0;
      memo_res_q <= '0;
    end else begin
      memo_vld_q <= memo_vld_d;
      memo_op1_q <= memo_op1_d;
      memo_op2_q <= memo_op2_d;
      memo_cmd_q <= memo_cmd_d;
      memo_res_q <= memo_res_d;
    end
  end
`else
  assign memo_hit  = 1'b0;
  assign memo_data = '0;
`endif

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    cmd_d   = cmd_q;
    tag_d   = tag_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (accept) begin
        op1_d = exe.REQ_OP1;
        op2_d = exe.REQ_OP2;
        cmd_d = exe.REQ_CMD;
        tag_d = exe.REQ_TAG;
        if (memo_hit) begin
          data_d  = memo_data;
          state_d = RESP;
        end else begin
          state_d = START;
        end
      end
      START: if (launch) begin
        cnt_d   = '0;
        // Once launched the divider cannot be stopped; a flush must drain it.
        state_d = exe.FLUSH ? DRAIN : WAIT;
      end else if (exe.FLUSH) begin
        state_d = IDLE;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (DIV_DONE) begin
          if (exe.FLUSH) begin
            state_d = IDLE;
          end else begin
            data_d  = DIV_RES;
            state_d = RESP;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (exe.FLUSH) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (DIV_DONE) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: if (exe.FLUSH || exe.RESP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    rvld_d  = (state_d == RESP);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      rvld_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      cmd_q   <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      rvld_q  <= rvld_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cmd_q   <= cmd_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign exe.REQ_READY  = ready_q;
  assign exe.RESP_VALID = rvld_q;
  assign exe.RESP_DATA  = data_q;
  assign exe.RESP_TAG   = tag_q;
  assign exe.BUSY       = busy_q;
  assign DIV_START      = launch;
  assign DIV_OP1        = op1_q;
  assign DIV_OP2        = op2_q;
  assign DIV_CMD        = cmd_q;
  assign ERR_TIMEOUT    = err_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed bench for div_sequencer with a behavioural
// divider (34-cycle latency, 2 cycles for divide-by-zero or equal operands).
module tb_div_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        div_start, div_done, div_busy, err;
  logic [31:0] div_op1, div_op2, div_res;
  logic [1:0]  div_cmd;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  div_sequencer_if #(.TAG_W(5)) exe();

  div_sequencer #(.TAG_W(5), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .exe(exe),
    .DIV_START(div_start), .DIV_OP1(div_op1), .DIV_OP2(div_op2), .DIV_CMD(div_cmd),
    .DIV_DONE(div_done), .DIV_BUSY(div_busy), .DIV_RES(div_res),
    .ERR_TIMEOUT(err)
  );

  // Divider model
  logic [7:0]  m_cnt;
  logic        m_busy;
  logic [31:0] m_res;
  logic        hang = 1'b0;

  function automatic logic [31:0] ref_div(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a; sb = b;
    case (c)
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b11:   return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_cnt <= 8'd0; m_busy <= 1'b0; m_res <= 32'd0;
    end else if (div_start) begin
      m_busy <= 1'b1;
      m_cnt  <= (div_op2 == 0 || div_op1 == div_op2) ? 8'd2 : 8'd34;
      m_res  <= ref_div(div_cmd, div_op1, div_op2);
    end else if (m_busy) begin
      m_cnt <= m_cnt - 8'd1;
      if (m_cnt == 8'd1) m_busy <= 1'b0;
    end
  end
  assign div_busy = m_busy;
  assign div_done = m_busy && (m_cnt == 8'd1) && !hang;
  assign div_res  = m_res;

  // All tasks start and end at a negedge.
  task automatic issue(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    int w = 0;
    while (exe.REQ_READY !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    n_cmp++; if (w >= 100) begin n_fail++; $display("FAIL issue_ready: REQ_READY=%b want 1", exe.REQ_READY); end
    exe.REQ_VALID = 1'b1; exe.REQ_CMD = c; exe.REQ_OP1 = a; exe.REQ_OP2 = b; exe.REQ_TAG = t;
    @(negedge clk);
    exe.REQ_VALID = 1'b0;
  endtask

  // Cycle 1 = cycle after accept; returns the cycle RESP_VALID is seen.
  task automatic wait_resp(output int cyc, output int starts, output int busy_low);
    cyc = 1; starts = 0; busy_low = 0;
    while (cyc < 200) begin
      if (div_start === 1'b1) starts++;
      if (exe.BUSY !== 1'b1) busy_low++;
      if (exe.RESP_VALID === 1'b1) break;
      @(negedge clk); cyc++;
    end
  endtask

  task automatic consume();
    exe.RESP_READY = 1'b1;
    @(negedge clk);
    exe.RESP_READY = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (exe.REQ_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", exe.REQ_READY); end
    n_cmp++; if ({exe.RESP_VALID, exe.BUSY, div_start, err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {exe.RESP_VALID, exe.BUSY, div_start, err}); end
    n_cmp++; if ({exe.RESP_DATA, exe.RESP_TAG} !== 37'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {exe.RESP_DATA, exe.RESP_TAG}); end
    n_cmp++; if ({div_op1, div_op2, div_cmd} !== 66'd0) begin n_fail++; $display("FAIL reset_ops: got %h want 0", {div_op1, div_op2, div_cmd}); end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (exe.REQ_READY !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", exe.REQ_READY); end
  endtask

  task automatic test_divu();
    int cyc, st, bl;
    issue(2'b10, 32'd100, 32'd7, 5'd3);
    n_cmp++; if (div_start !== 1'b1) begin n_fail++; $display("FAIL divu_start_c1: got %b want 1", div_start); end
    n_cmp++; if ({div_op1, div_op2, div_cmd} !== {32'd100, 32'd7, 2'b10}) begin n_fail++; $display("FAIL divu_ops: got %h want %h", {div_op1, div_op2, div_cmd}, {32'd100, 32'd7, 2'b10}); end
    wait_resp(cyc, st, bl);
    n_cmp++; if (cyc !== 36) begin n_fail++; $display("FAIL divu_latency: got %0d want 36", cyc); end
    n_cmp++; if (st !== 1) begin n_fail++; $display("FAIL divu_starts: got %0d want 1", st); end
    n_cmp++; if (bl !== 0) begin n_fail++; $display("FAIL divu_busy: low cycles %0d want 0", bl); end
    n_cmp++; if ({exe.RESP_DATA, exe.RESP_TAG} !== {32'd14, 5'd3}) begin n_fail++; $display("FAIL divu_result: got %h/%0d want 0000000e/3", exe.RESP_DATA, exe.RESP_TAG); end
    n_cmp++; if ({div_op1, div_op2, div_cmd} !== {32'd100, 32'd7, 2'b10}) begin n_fail++; $display("FAIL divu_ops_held: got %h", {div_op1, div_op2, div_cmd}); end
    consume();
    n_cmp++; if ({exe.BUSY, exe.REQ_READY, exe.RESP_VALID} !== 3'b010) begin n_fail++; $display("FAIL divu_idle: busy/ready/rvld got %b want 010", {exe.BUSY, exe.REQ_READY, exe.RESP_VALID}); end
  endtask

  task automatic test_rem_hold();
    int cyc, st, bl, bad = 0;
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd5);
    wait_resp(cyc, st, bl);
    n_cmp++; if (cyc !== 36 || exe.RESP_DATA !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_result: got %h at %0d want ffffffff at 36", exe.RESP_DATA, cyc); end
    repeat (5) begin
      @(negedge clk);
      if (exe.RESP_VALID !== 1'b1 || exe.RESP_DATA !== 32'hFFFF_FFFF || exe.RESP_TAG !== 5'd5 || exe.REQ_READY !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rem_hold: %0d unstable cycles want 0", bad); end
    consume();
    n_cmp++; if (exe.REQ_READY !== 1'b1) begin n_fail++; $display("FAIL rem_ready_after: got %b want 1", exe.REQ_READY); end
  endtask

  task automatic test_div0();
    int cyc, st, bl;
    issue(2'b01, 32'd5, 32'd0, 5'd7);   // back to back with previous response
    wait_resp(cyc, st, bl);
    n_cmp++; if (cyc !== 4) begin n_fail++; $display("FAIL div0_latency: got %0d want 4", cyc); end
    n_cmp++; if ({exe.RESP_DATA, exe.RESP_TAG} !== {32'hFFFF_FFFF, 5'd7}) begin n_fail++; $display("FAIL div0_result: got %h/%0d want ffffffff/7", exe.RESP_DATA, exe.RESP_TAG); end
    consume();
    issue(2'b00, 32'd9, 32'd9, 5'd1);
    wait_resp(cyc, st, bl);
    n_cmp++; if (cyc !== 4 || exe.RESP_DATA !== 32'd0 || exe.RESP_TAG !== 5'd1) begin n_fail++; $display("FAIL remu_eq: got %h/%0d at %0d want 0/1 at 4", exe.RESP_DATA, exe.RESP_TAG, cyc); end
    consume();
  endtask

  task automatic test_flush();
    int cyc = 1, rv = 0, st, bl;
    issue(2'b10, 32'd1000, 32'd3, 5'd9);
    while (cyc < 10) begin @(negedge clk); cyc++; end
    exe.FLUSH = 1'b1;
    @(negedge clk); cyc++;
    exe.FLUSH = 1'b0;
    n_cmp++; if ({exe.BUSY, exe.REQ_READY} !== 2'b10) begin n_fail++; $display("FAIL flush_drain: busy/ready got %b want 10", {exe.BUSY, exe.REQ_READY}); end
    while (exe.REQ_READY !== 1'b1 && cyc < 200) begin
      if (exe.RESP_VALID === 1'b1) rv++;
      @(negedge clk); cyc++;
    end
    n_cmp++; if (cyc !== 36) begin n_fail++; $display("FAIL flush_ready_cycle: got %0d want 36", cyc); end
    n_cmp++; if (rv !== 0 || exe.RESP_VALID !== 1'b0) begin n_fail++; $display("FAIL flush_no_resp: %0d valid cycles want 0", rv); end
    issue(2'b10, 32'd1000, 32'd3, 5'd10);
    wait_resp(cyc, st, bl);
    n_cmp++; if (cyc !== 36 || exe.RESP_DATA !== 32'd333 || exe.RESP_TAG !== 5'd10) begin n_fail++; $display("FAIL flush_next: got %0d/%0d at %0d want 333/10 at 36", exe.RESP_DATA, exe.RESP_TAG, cyc); end
    consume();
  endtask

  task automatic test_timeout();
    int cyc = 1, rv = 0, st, bl;
    hang = 1'b1;
    issue(2'b10, 32'd50, 32'd5, 5'd2);
    while (err !== 1'b1 && cyc < 200) begin
      if (exe.RESP_VALID === 1'b1) rv++;
      @(negedge clk); cyc++;
    end
    n_cmp++; if (cyc !== 65) begin n_fail++; $display("FAIL timeout_cycle: got %0d want 65", cyc); end
    n_cmp++; if ({exe.REQ_READY, exe.BUSY, exe.RESP_VALID} !== 3'b100 || rv !== 0) begin n_fail++; $display("FAIL timeout_idle: ready/busy/rvld got %b rv %0d want 100 rv 0", {exe.REQ_READY, exe.BUSY, exe.RESP_VALID}, rv); end
    hang = 1'b0;
    repeat (20) @(negedge clk);
    issue(2'b10, 32'd20, 32'd4, 5'd4);
    wait_resp(cyc, st, bl);
    n_cmp++; if (cyc !== 36 || exe.RESP_DATA !== 32'd5) begin n_fail++; $display("FAIL timeout_recover: got %0d at %0d want 5 at 36", exe.RESP_DATA, cyc); end
    consume();
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", err); end
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_reset: got %b want 0", err); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_memo();
    int cyc, st, bl;
    issue(2'b10, 32'd100, 32'd7, 5'd3);
    wait_resp(cyc, st, bl);
    n_cmp++; if (cyc !== 36 || exe.RESP_DATA !== 32'd14) begin n_fail++; $display("FAIL memo_first: got %0d at %0d want 14 at 36", exe.RESP_DATA, cyc); end
    consume();
    issue(2'b10, 32'd100, 32'd7, 5'd6);
    wait_resp(cyc, st, bl);
`ifdef DIV_MEMO_EN
    n_cmp++; if (cyc !== 1 || st !== 0) begin n_fail++; $display("FAIL memo_hit: got cycle %0d starts %0d want 1/0", cyc, st); end
`else
    n_cmp++; if (cyc !== 36 || st !== 1) begin n_fail++; $display("FAIL memo_none: got cycle %0d starts %0d want 36/1", cyc, st); end
`endif
    n_cmp++; if ({exe.RESP_DATA, exe.RESP_TAG} !== {32'd14, 5'd6}) begin n_fail++; $display("FAIL memo_result: got %h/%0d want 0000000e/6", exe.RESP_DATA, exe.RESP_TAG); end
    consume();
  endtask

  initial begin
    exe.REQ_VALID = 1'b0; exe.REQ_OP1 = '0; exe.REQ_OP2 = '0; exe.REQ_CMD = '0;
    exe.REQ_TAG = '0; exe.FLUSH = 1'b0; exe.RESP_READY = 1'b0;
    test_reset();
    test_divu();
    test_rem_hold();
    test_div0();
    test_flush();
    test_timeout();
    test_memo();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
